seg7_decode: RTL and testbench

SEG7_DECODE -- requirements
Module: seg7_decode

---
 rtl/seg7_pkg.sv | 23 ++
 rtl/seg7_code_lookup.sv | 21 ++
 rtl/seg7_decode.sv | 125 ++++++++++++
 tb/tb_seg7_decode.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment bus decoder: digit-enable bit
// positions on the hex bus, the segment code table and the digit index type.
package seg7_pkg;

  localparam int EN_D1 = 11;
  localparam int EN_D2 = 8;
  localparam int EN_D3 = 7;
  localparam int EN_D4 = 5;

  typedef enum logic [1:0] {
    DIG_D1 = 2'd0,
    DIG_D2 = 2'd1,
    DIG_D3 = 2'd2,
    DIG_D4 = 2'd3
  } digit_t;

  // Entry i is the active-high segment pattern that displays nibble i.
  localparam logic [7:0] SEG_CODES [16] = '{
    8'hEB, 8'h28, 8'hB3, 8'hBA, 8'h78, 8'hDA, 8'hDB, 8'hA8,
    8'hFB, 8'hFA, 8'hF9, 8'h5B, 8'hC3, 8'h3B, 8'hD3, 8'hD1
  };

endpackage

// File: rtl/seg7_code_lookup.sv
// Combinational reverse lookup from a segment pattern to its hex nibble.
import seg7_pkg::*;

module seg7_code_lookup (
  input  logic [7:0] seg,
  output logic [3:0] nibble,
  output logic       hit
);

  always_comb begin
    nibble = 4'h0;
    hit    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_CODES[i]) begin
        nibble = 4'(i);
        hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_decode.sv
// Recovers a 4-digit value from a multiplexed seven-segment display bus.
// Define SEG7_DECODE_STABLE_EN to require STABLE_CNT identical samples before capture.
import seg7_pkg::*;

module seg7_decode #(
  parameter int STABLE_CNT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] hex,
  output logic [15:0] value,
  output logic        value_vld,
  output logic        sel_err,
  output logic        code_err,
  output logic [7:0]  frame_cnt
);

  if (STABLE_CNT < 2 || STABLE_CNT > 15) begin : g_bad_stable_cnt
    $error("seg7_decode: STABLE_CNT must be in 2..15");
  end

  logic [11:0] s1;
  logic [3:0]  seen;
  logic [3:0]  shadow [4];
  logic [3:0]  merged [4];
  logic [3:0]  en_n;
  logic [7:0]  seg;
  logic [3:0]  nibble;
  logic        hit;
  logic        single;
  logic        multi;
  logic        stable;
  digit_t      idx;
  logic [3:0]  dig_mask;
  logic [15:0] frame_value;

  // en_n bit i belongs to digit i (D1..D4), still active low.
  assign en_n = {s1[EN_D4], s1[EN_D3], s1[EN_D2], s1[EN_D1]};
  assign seg  = {s1[10], s1[9], s1[6], s1[4], s1[3], s1[2], s1[1], s1[0]};

  seg7_code_lookup u_lookup (
    .seg    (seg),
    .nibble (nibble),
    .hit    (hit)
  );

  always_comb begin
    idx    = DIG_D1;
    single = 1'b0;
    multi  = 1'b0;
    case (en_n)
      4'b1110: begin idx = DIG_D1; single = 1'b1; end
      4'b1101: begin idx = DIG_D2; single = 1'b1; end
      4'b1011: begin idx = DIG_D3; single = 1'b1; end
      4'b0111: begin idx = DIG_D4; single = 1'b1; end
      4'b1111: ;
      default: multi = 1'b1;
    endcase
  end

  assign dig_mask = 4'b0001 << idx;

  // The completing digit is not yet in its shadow, so splice it in here.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      merged[i] = (2'(i) == idx) ? nibble : shadow[i];
    end
    frame_value = {merged[0], merged[1], merged[2], merged[3]};
  end

`ifdef SEG7_DECODE_STABLE_EN
  // Counts samples of the current S1 value; saturates one past the
  // threshold so a long run captures exactly once.
  logic [4:0] stab_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stab_cnt <= 5'd0;
    end else if (hex != s1) begin
      stab_cnt <= 5'd1;
    end else if (stab_cnt <= 5'(STABLE_CNT)) begin
      stab_cnt <= stab_cnt + 5'd1;
    end
  end

  assign stable = (stab_cnt == 5'(STABLE_CNT));
`else
  assign stable = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= 12'hFFF;
      seen      <= 4'h0;
      value     <= 16'h0000;
      value_vld <= 1'b0;
      sel_err   <= 1'b0;
      code_err  <= 1'b0;
      frame_cnt <= 8'h00;
      for (int i = 0; i < 4; i++) shadow[i] <= 4'h0;
    end else begin
      s1        <= hex;
      value_vld <= 1'b0;
      sel_err   <= 1'b0;
      code_err  <= 1'b0;
      if (multi) begin
        sel_err <= 1'b1;
      end else if (single && !hit) begin
        code_err  <= 1'b1;
        seen[idx] <= 1'b0;
      end else if (single && stable) begin
        shadow[idx] <= nibble;
        if ((seen | dig_mask) == 4'hF) begin
          value     <= frame_value;
          value_vld <= 1'b1;
          frame_cnt <= frame_cnt + 8'd1;
          seen      <= 4'h0;
        end else begin
          seen <= seen | dig_mask;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_decode.sv
// Randomized scoreboard bench for seg7_decode; the reference model works on
// whole bus words and digit/nibble tables rather than on the decoder's internals.
module tb_seg7_decode;

`ifdef SEG7_DECODE_STABLE_EN
  localparam int STAB = 3;
`else
  localparam int STAB = 1;
`endif
  localparam int W = 47;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] hex = 12'hFFF;
  logic [15:0] value;
  logic        value_vld;
  logic        sel_err;
  logic        code_err;
  logic [7:0]  frame_cnt;

  seg7_decode #(.STABLE_CNT(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .hex       (hex),
    .value     (value),
    .value_vld (value_vld),
    .sel_err   (sel_err),
    .code_err  (code_err),
    .frame_cnt (frame_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference tables ----------------
  logic [7:0] code_tab [16] = '{
    8'hEB, 8'h28, 8'hB3, 8'hBA, 8'h78, 8'hDA, 8'hDB, 8'hA8,
    8'hFB, 8'hFA, 8'hF9, 8'h5B, 8'hC3, 8'h3B, 8'hD3, 8'hD1
  };
  int en_pos  [4] = '{11, 8, 7, 5};
  int seg_pos [8] = '{0, 1, 2, 3, 4, 6, 9, 10};

  // ---------------- scoreboard state ----------------
  // record: {cycle[19:0], {vld,sel,code}, frame_cnt[7:0], value[15:0]}
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  logic [11:0] m_prev;
  int          m_run;
  logic [3:0]  m_seen;
  int          m_shadow [4];
  logic [15:0] m_last;
  int          m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [11:0] make_word(input int d, input logic [7:0] seg);
    logic [11:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) w[en_pos[k]] = (k != d);
    for (int i = 0; i < 8; i++) w[seg_pos[i]] = seg[i];
    return w;
  endfunction

  task automatic model_reset();
    m_prev = 12'hFFF;
    m_run  = 0;
    m_seen = 4'h0;
    m_last = 16'h0;
    m_cnt  = 0;
    for (int i = 0; i < 4; i++) m_shadow[i] = 0;
  endtask

  task automatic push(input int c, input logic [2:0] kind);
    exp_q.push_back({20'(c + 2), kind, 8'(m_cnt), m_last});
  endtask

  // One bus word seen for one cycle, driven in cycle c.
  task automatic model_step(input logic [11:0] w, input int c);
    int lows, dig, nib;
    logic [7:0] seg;
    lows = 0; dig = 0; nib = -1;
    if (w == m_prev) m_run++;
    else m_run = 1;
    m_prev = w;
    for (int k = 0; k < 4; k++) if (!w[en_pos[k]]) begin lows++; dig = k; end
    for (int i = 0; i < 8; i++) seg[i] = w[seg_pos[i]];
    for (int j = 0; j < 16; j++) if (seg == code_tab[j]) nib = j;
    if (lows >= 2) begin
      push(c, 3'b010);
    end else if (lows == 1) begin
      if (nib < 0) begin
        m_seen[dig] = 1'b0;
        push(c, 3'b001);
      end else if (STAB == 1 || m_run == STAB) begin
        m_shadow[dig] = nib;
        m_seen[dig]   = 1'b1;
        if (m_seen == 4'hF) begin
          m_last = {4'(m_shadow[0]), 4'(m_shadow[1]), 4'(m_shadow[2]), 4'(m_shadow[3])};
          m_cnt  = (m_cnt + 1) % 256;
          m_seen = 4'h0;
          push(c, 3'b100);
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [11:0] w, input int hold);
    for (int h = 0; h < hold; h++) begin
      hex = w;
      model_step(w, cyc);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_digit(input int d, input logic [3:0] n, input int hold);
    drive(make_word(d, code_tab[n]), hold);
  endtask

  task automatic send_frame(input logic [15:0] v, input int hold);
    send_digit(3, v[3:0],   hold);
    send_digit(2, v[7:4],   hold);
    send_digit(1, v[11:8],  hold);
    send_digit(0, v[15:12], hold);
  endtask

  task automatic reset_dut();
    hex = 12'hFFF;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic check_reset_values();
    check("rst_value",     32'(value),     32'h0);
    check("rst_value_vld", 32'(value_vld), 32'h0);
    check("rst_sel_err",   32'(sel_err),   32'h0);
    check("rst_code_err",  32'(code_err),  32'h0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'h0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst && (value_vld || sel_err || code_err)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_pulse actual=%b%b%b required=none (cycle %0d)",
                 value_vld, sel_err, code_err, cyc);
      end else begin
        e = exp_q.pop_front();
        check("pulse_cycle", 32'(cyc), 32'(e[46:27]));
        check("pulse_kind",  32'({value_vld, sel_err, code_err}), 32'(e[26:24]));
        check("frame_cnt",   32'(frame_cnt), 32'(e[23:16]));
        check("value",       32'(value), 32'(e[15:0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [11:0] w;
    int kind;
    model_reset();
    reset_dut();
    check_reset_values();

    // Basic frame, then a direct check on the absolute result.
    send_frame(16'h1234, STAB);
    drive(12'hFFF, 3);
    check("frame_1234_value", 32'(value), 32'h1234);
    check("frame_1234_cnt",   32'(frame_cnt), 32'h1);

    // Long blank in mid-frame must not disturb the digits already seen.
    send_digit(0, 4'h5, STAB);
    send_digit(1, 4'h6, STAB);
    drive(12'hFFF, 10);
    send_digit(2, 4'h7, STAB);
    send_digit(3, 4'h8, STAB);
    drive(12'hFFF, 3);
    check("blank_gap_value", 32'(value), 32'h5678);

    // Two enables low.
    drive(12'h5D8, 1);
    drive(12'hFFF, 3);

    // Bad code on D4 invalidates the earlier D4; the frame needs a fresh one.
    send_digit(3, 4'h9, STAB);
    drive(12'hFDF, 1);
    send_digit(0, 4'hC, STAB);
    send_digit(1, 4'hD, STAB);
    send_digit(2, 4'hE, STAB);
    drive(12'hFFF, 3);
    check("code_err_no_frame", 32'(frame_cnt), 32'h2);
    send_digit(3, 4'hA, STAB);
    drive(12'hFFF, 3);
    check("code_err_refill", 32'(value), 32'hCDEA);

    // Randomized mix of valid digits, blanks, raw words and error words.
    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 5)      w = make_word($urandom_range(0, 3), code_tab[$urandom_range(0, 15)]);
      else if (kind == 6) w = 12'hFFF;
      else if (kind == 7) w = 12'($urandom_range(0, 4095));
      else if (kind == 8) w = make_word($urandom_range(0, 3), 8'($urandom_range(0, 255))) & ~12'h900;
      else                w = make_word($urandom_range(0, 3), 8'($urandom_range(0, 255)));
      drive(w, $urandom_range(1, 4));
    end
    drive(12'hFFF, 3);

    // Counter wrap over 256 frames, then a reset that drops a partial frame.
    reset_dut();
    for (int f = 0; f < 256; f++) send_frame(16'($urandom_range(0, 65535)), STAB);
    drive(12'hFFF, 3);
    check("wrap_frame_cnt", 32'(frame_cnt), 32'h0);
    send_digit(3, 4'h1, STAB);
    send_digit(2, 4'h2, STAB);
    drive(12'hFFF, 3);
    reset_dut();
    check_reset_values();
    send_digit(1, 4'h3, STAB);
    send_digit(0, 4'h4, STAB);
    drive(12'hFFF, 3);
    check("partial_after_rst_cnt", 32'(frame_cnt), 32'h0);
    send_frame(16'hBEEF, STAB);
    drive(12'hFFF, 3);
    check("fresh_frame_cnt", 32'(frame_cnt), 32'h1);

    // Holds just short of and exactly at the filter threshold.
    send_frame(16'h2468, 2);
    drive(12'hFFF, 3);
    send_frame(16'h1357, 3);
    drive(12'hFFF, 5);

    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
